// File: rtl/voice_sequencer.sv
// voice_sequencer: per-sample envelope voice scheduler plus round-robin arbiter for the shared multiplier.
// Define VSEQ_WDT_EN to add the envelope-handshake watchdog and its sticky wdt_err_o flag.
module voice_sequencer #(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned WDT_CYCLES = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sample_tick_i,
    output logic       env_start_o,
    output logic [1:0] env_voice_idx_o,
    input  logic       env_ready_i,
    input  logic       env_mult_req_i,
    output logic       env_mult_ready_o,
    input  logic       flt_mult_req_i,
    output logic       flt_mult_ready_o,
    output logic       mult_start_o,
    output logic       mult_sel_o,
    input  logic       mult_ready_i,
    output logic       frame_done_o,
    output logic       overrun_o,
    output logic       busy_o
`ifdef VSEQ_WDT_EN
    ,
    output logic       wdt_err_o
`endif
);

    if (NUM_VOICES < 1 || NUM_VOICES > 4) begin : g_bad_voices
        $error("NUM_VOICES must be in 1..4");
    end
    if (WDT_CYCLES < 1 || WDT_CYCLES > 255) begin : g_bad_wdt
        $error("WDT_CYCLES must be in 1..255");
    end

    localparam logic [1:0] LAST_VOICE = 2'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t     state;
    logic [1:0] voice;
    logic       wdt_fire;

    assign env_voice_idx_o = voice;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            voice        <= '0;
            env_start_o  <= 1'b0;
            frame_done_o <= 1'b0;
            overrun_o    <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            env_start_o  <= 1'b0;
            frame_done_o <= 1'b0;
            // A tick that lands while a frame is still running is dropped, not queued.
            if (sample_tick_i && state != IDLE) overrun_o <= 1'b1;
            case (state)
                IDLE: if (sample_tick_i) begin
                    state       <= START;
                    env_start_o <= 1'b1;
                    busy_o      <= 1'b1;
                end
                START: state <= WAIT;
                WAIT: if (env_ready_i || wdt_fire) begin
                    if (voice == LAST_VOICE) begin
                        state        <= DONE;
                        frame_done_o <= 1'b1;
                    end else begin
                        voice       <= voice + 2'd1;
                        state       <= START;
                        env_start_o <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    voice  <= '0;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VSEQ_WDT_EN
    localparam logic [7:0] WDT_LAST = 8'(WDT_CYCLES - 1);
    logic [7:0] wdt_cnt;

    // Fires on the WDT_CYCLES-th consecutive WAIT cycle without a ready.
    assign wdt_fire = (state == WAIT) && !env_ready_i && (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdt_cnt   <= '0;
            wdt_err_o <= 1'b0;
        end else begin
            if (state == START) wdt_cnt <= '0;
            else if (state == WAIT && !env_ready_i && !wdt_fire) wdt_cnt <= wdt_cnt + 8'd1;
            if (wdt_fire) wdt_err_o <= 1'b1;
        end
    end
`else
    assign wdt_fire = 1'b0;
`endif

    // Multiplier arbiter: 0 = envelope, 1 = filter.
    logic env_pend, flt_pend, mult_busy, rr_last;
    logic env_want, flt_want, mult_free, grant, grant_sel;

    // Same-cycle requests take part in arbitration so none is lost around a grant or ready.
    assign env_want  = env_pend | env_mult_req_i;
    assign flt_want  = flt_pend | flt_mult_req_i;
    assign mult_free = ~mult_busy | mult_ready_i;
    assign grant     = mult_free & (env_want | flt_want);
    assign grant_sel = (env_want & flt_want) ? ~rr_last : flt_want;

    assign env_mult_ready_o = mult_busy & mult_ready_i & ~mult_sel_o;
    assign flt_mult_ready_o = mult_busy & mult_ready_i &  mult_sel_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            env_pend     <= 1'b0;
            flt_pend     <= 1'b0;
            mult_busy    <= 1'b0;
            rr_last      <= 1'b1;
            mult_start_o <= 1'b0;
            mult_sel_o   <= 1'b0;
        end else begin
            mult_start_o <= grant;
            env_pend     <= env_want & ~(grant & ~grant_sel);
            flt_pend     <= flt_want & ~(grant &  grant_sel);
            if (grant) begin
                mult_sel_o <= grant_sel;
                rr_last    <= grant_sel;
                mult_busy  <= 1'b1;
            end else if (mult_ready_i) begin
                mult_busy <= 1'b0;
            end
        end
    end

endmodule
